// File: rtl/lcd_pkg.sv
// Shared constants and encodings for the character LCD writer.
// Holds the panel command bytes, the FSM state encoding and small byte helpers.
package lcd_pkg;

   localparam logic [7:0] FUNC_SET = 8'h38;
   localparam logic [7:0] DISP_ON  = 8'h0C;
   localparam logic [7:0] CLEAR    = 8'h01;
   localparam logic [7:0] ENTRY    = 8'h06;
   localparam logic [7:0] LINE0    = 8'h80;
   localparam logic [7:0] LINE1    = 8'hC0;
   localparam logic [7:0] CR       = 8'h0D;

   typedef enum logic [2:0] {
      ST_PWR,
      ST_SETUP,
      ST_PULSE,
      ST_WAIT,
      ST_IDLE
   } lcd_state_t;

   // What the writer must still issue after the current write's WAIT finishes.
   typedef enum logic [1:0] {
      FOL_NONE,
      FOL_LINE1,
      FOL_CLEAR,
      FOL_HOME
   } lcd_follow_t;

   function automatic logic [7:0] init_cmd(input logic [1:0] step);
      logic [7:0] cmd;
      case (step)
         2'd0:    cmd = FUNC_SET;
         2'd1:    cmd = DISP_ON;
         2'd2:    cmd = CLEAR;
         default: cmd = ENTRY;
      endcase
      return cmd;
   endfunction

   function automatic logic is_printable(input logic [7:0] b);
      return (b >= 8'h20) && (b <= 8'h7E);
   endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter; done is high during the last cycle of a loaded delay.
// A load value of 0 behaves like 1 so every timed state lasts at least one clock.
module lcd_delay_counter #(
   parameter int W = 20
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (!reset)
         count <= '0;
      else if (load)
         count <= (load_val == '0) ? W'(1) : load_val;
      else if (count != '0)
         count <= count - W'(1);
   end

   assign done = (count == W'(1));

endmodule

// File: rtl/lcd_char_writer.sv
// HD44780-style character writer: powers up and initialises the panel, then turns
// incoming bytes into data writes with automatic line wrap, screen wrap and CR handling.
module lcd_char_writer
   import lcd_pkg::*;
#(
   parameter int PWRUP_CYC    = 750000,
   parameter int E_HIGH_CYC   = 25,
   parameter int CMD_WAIT_CYC = 2000,
   parameter int CLR_WAIT_CYC = 82000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] lcd_data,
   input  logic       lcd_en,
   output logic       busy,
   output logic [9:0] lcd_bus,
   output logic       lcd_e
);

   localparam int MAX_A  = (PWRUP_CYC > CLR_WAIT_CYC) ? PWRUP_CYC : CLR_WAIT_CYC;
   localparam int MAX_B  = (E_HIGH_CYC > CMD_WAIT_CYC) ? E_HIGH_CYC : CMD_WAIT_CYC;
   localparam int MAX_V  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAX_G  = (MAX_V < 1) ? 1 : MAX_V;
   localparam int CW     = $clog2(MAX_G + 1);

   // The first PWR clock arms the counter, so it is loaded with one less.
   localparam logic [CW-1:0] PWR_LOAD = CW'((PWRUP_CYC > 1) ? PWRUP_CYC - 1 : 1);
   localparam logic [CW-1:0] E_LOAD   = CW'(E_HIGH_CYC);
   localparam logic [CW-1:0] CMD_LOAD = CW'(CMD_WAIT_CYC);
   localparam logic [CW-1:0] CLR_LOAD = CW'(CLR_WAIT_CYC);

   lcd_state_t    state;
   lcd_follow_t   follow;
   logic          line;
   logic [3:0]    col;
   logic [1:0]    init_step;
   logic          init_active;
   logic          pwr_armed;
   logic          cnt_load;
   logic [CW-1:0] cnt_val;
   logic          cnt_done;

   lcd_delay_counter #(.W(CW)) u_delay (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_val),
      .done     (cnt_done)
   );

   // Each timed state's delay is loaded on the edge that enters it.
   always_comb begin
      cnt_load = 1'b0;
      cnt_val  = '0;
      case (state)
         ST_PWR: begin
            if (!pwr_armed) begin
               cnt_load = 1'b1;
               cnt_val  = PWR_LOAD;
            end
         end
         ST_SETUP: begin
            cnt_load = 1'b1;
            cnt_val  = E_LOAD;
         end
         ST_PULSE: begin
            if (cnt_done) begin
               cnt_load = 1'b1;
               cnt_val  = (lcd_bus == {2'b00, CLEAR}) ? CLR_LOAD : CMD_LOAD;
            end
         end
         default: begin
            cnt_load = 1'b0;
            cnt_val  = '0;
         end
      endcase
   end

   // Main sequencer; the bus value set on entry to SETUP is held through WAIT.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_PWR;
         follow      <= FOL_NONE;
         lcd_e       <= 1'b0;
         lcd_bus     <= 10'h000;
         busy        <= 1'b1;
         line        <= 1'b0;
         col         <= 4'd0;
         init_step   <= 2'd0;
         init_active <= 1'b1;
         pwr_armed   <= 1'b0;
      end else begin
         case (state)
            ST_PWR: begin
               if (!pwr_armed)
                  pwr_armed <= 1'b1;
               else if (cnt_done) begin
                  lcd_bus <= {2'b00, init_cmd(init_step)};
                  state   <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               lcd_e <= 1'b1;
               state <= ST_PULSE;
            end
            ST_PULSE: begin
               if (cnt_done) begin
                  lcd_e <= 1'b0;
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt_done) begin
                  if (init_active) begin
                     if (init_step == 2'd3) begin
                        init_active <= 1'b0;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                     end else begin
                        init_step <= init_step + 2'd1;
                        lcd_bus   <= {2'b00, init_cmd(init_step + 2'd1)};
                        state     <= ST_SETUP;
                     end
                  end else begin
                     case (follow)
                        FOL_LINE1: begin
                           lcd_bus <= {2'b00, LINE1};
                           follow  <= FOL_NONE;
                           state   <= ST_SETUP;
                        end
                        FOL_CLEAR: begin
                           lcd_bus <= {2'b00, CLEAR};
                           follow  <= FOL_HOME;
                           state   <= ST_SETUP;
                        end
                        FOL_HOME: begin
                           lcd_bus <= {2'b00, LINE0};
                           follow  <= FOL_NONE;
                           state   <= ST_SETUP;
                        end
                        default: begin
                           busy  <= 1'b0;
                           state <= ST_IDLE;
                        end
                     endcase
                  end
               end
            end
            ST_IDLE: begin
               if (lcd_en) begin
                  if (is_printable(lcd_data)) begin
                     lcd_bus <= {2'b10, lcd_data};
                     busy    <= 1'b1;
                     state   <= ST_SETUP;
                     if (col == 4'd15) begin
                        col    <= 4'd0;
                        line   <= ~line;
                        follow <= line ? FOL_CLEAR : FOL_LINE1;
                     end else
                        col <= col + 4'd1;
                  end else if (lcd_data == CR) begin
                     lcd_bus <= {2'b00, (line ? LINE0 : LINE1)};
                     line    <= ~line;
                     col     <= 4'd0;
                     busy    <= 1'b1;
                     state   <= ST_SETUP;
                  end
               end
            end
            default: begin
               state <= ST_PWR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_char_writer.sv
// Directed bench for lcd_char_writer with short delays; expected bus values and
// timings are hand-computed from PWRUP=20, E_HIGH=3, CMD_WAIT=8, CLR_WAIT=30.
module tb_lcd_char_writer;

   localparam int PWR_C = 20;
   localparam int EH_C  = 3;
   localparam int CMD_C = 8;
   localparam int CLR_C = 30;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] lcd_data = 8'h00;
   logic       lcd_en = 1'b0;
   logic       busy;
   logic [9:0] lcd_bus;
   logic       lcd_e;

   int checks = 0;
   int passes = 0;

   lcd_char_writer #(
      .PWRUP_CYC    (PWR_C),
      .E_HIGH_CYC   (EH_C),
      .CMD_WAIT_CYC (CMD_C),
      .CLR_WAIT_CYC (CLR_C)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .lcd_data (lcd_data),
      .lcd_en   (lcd_en),
      .busy     (busy),
      .lcd_bus  (lcd_bus),
      .lcd_e    (lcd_e)
   );

   always #5 clk = ~clk;

   // Presents a byte for exactly one rising edge; returns at the following negedge.
   task automatic send_byte(input logic [7:0] b);
      lcd_data = b;
      lcd_en   = 1'b1;
      @(negedge clk);
      lcd_en   = 1'b0;
   endtask

   // Finds the next lcd_e pulse and measures its high width and the WAIT length
   // (lcd_e low, busy high, bus unchanged) that follows it.
   task automatic wait_pulse(output logic found, output logic [9:0] bus,
                             output int high, output int waitc);
      found = 1'b0;
      bus   = '0;
      high  = 0;
      waitc = 0;
      for (int i = 0; i < 400 && !found; i++) begin
         if (lcd_e) found = 1'b1;
         else @(negedge clk);
      end
      if (found) begin
         bus = lcd_bus;
         while (lcd_e && high < 400) begin
            high++;
            @(negedge clk);
         end
         while (!lcd_e && busy && lcd_bus == bus && waitc < 400) begin
            waitc++;
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      lcd_data = 8'h41;
      lcd_en   = 1'b1;
      repeat (3) @(negedge clk);
      lcd_en = 1'b0;
      checks++; if (lcd_e !== 1'b0) $display("[TB] FAIL reset_lcd_e: got %b expected 0", lcd_e); else passes++;
      checks++; if (lcd_bus !== 10'h000) $display("[TB] FAIL reset_bus: got %h expected 000", lcd_bus); else passes++;
      checks++; if (busy !== 1'b1) $display("[TB] FAIL reset_busy: got %b expected 1", busy); else passes++;
   endtask

   task automatic test_init();
      logic [9:0] exp_bus [4];
      logic       found;
      logic [9:0] bus;
      int         high, waitc, pwr;
      exp_bus = '{10'h038, 10'h00C, 10'h001, 10'h006};
      reset = 1'b1;
      pwr = 0;
      while (busy && !lcd_e && lcd_bus == 10'h000 && pwr < 200) begin
         pwr++;
         @(negedge clk);
      end
      checks++; if (pwr !== PWR_C) $display("[TB] FAIL init_pwr_len: got %0d expected %0d", pwr, PWR_C); else passes++;
      checks++; if (lcd_e !== 1'b0 || lcd_bus !== 10'h038) $display("[TB] FAIL init_setup: got e=%b bus=%h expected e=0 bus=038", lcd_e, lcd_bus); else passes++;
      for (int k = 0; k < 4; k++) begin
         wait_pulse(found, bus, high, waitc);
         checks++; if (!found || bus !== exp_bus[k]) $display("[TB] FAIL init_cmd%0d: got found=%b bus=%h expected %h", k, found, bus, exp_bus[k]); else passes++;
         checks++; if (high !== EH_C) $display("[TB] FAIL init_high%0d: got %0d expected %0d", k, high, EH_C); else passes++;
         checks++; if (waitc !== ((k == 2) ? CLR_C : CMD_C)) $display("[TB] FAIL init_wait%0d: got %0d expected %0d", k, waitc, (k == 2) ? CLR_C : CMD_C); else passes++;
      end
      checks++; if (busy !== 1'b0) $display("[TB] FAIL init_idle: got busy=%b expected 0", busy); else passes++;
   endtask

   task automatic test_single_char();
      logic       found;
      logic [9:0] bus;
      int         high, waitc;
      send_byte(8'h41);
      checks++; if (busy !== 1'b1) $display("[TB] FAIL char_busy_next: got %b expected 1", busy); else passes++;
      checks++; if (lcd_e !== 1'b0 || lcd_bus !== 10'h241) $display("[TB] FAIL char_setup: got e=%b bus=%h expected e=0 bus=241", lcd_e, lcd_bus); else passes++;
      @(negedge clk);
      checks++; if (lcd_e !== 1'b1) $display("[TB] FAIL char_e_rise: got %b expected 1", lcd_e); else passes++;
      wait_pulse(found, bus, high, waitc);
      checks++; if (!found || bus !== 10'h241) $display("[TB] FAIL char_bus: got %h expected 241", bus); else passes++;
      checks++; if (high !== EH_C) $display("[TB] FAIL char_high: got %0d expected %0d", high, EH_C); else passes++;
      checks++; if (waitc !== CMD_C) $display("[TB] FAIL char_wait: got %0d expected %0d", waitc, CMD_C); else passes++;
      checks++; if (busy !== 1'b0) $display("[TB] FAIL char_idle: got %b expected 0", busy); else passes++;
   endtask

   task automatic test_cr_and_discard();
      logic       found;
      logic [9:0] bus;
      int         high, waitc, activity;
      send_byte(8'h0A);
      activity = 0;
      repeat (10) begin
         if (lcd_e || busy) activity++;
         @(negedge clk);
      end
      checks++; if (activity !== 0) $display("[TB] FAIL discard_0a: got %0d active cycles expected 0", activity); else passes++;
      send_byte(8'h0D);
      lcd_data = 8'h42;
      lcd_en   = 1'b1;
      repeat (2) @(negedge clk);
      lcd_en = 1'b0;
      wait_pulse(found, bus, high, waitc);
      checks++; if (!found || bus !== 10'h0C0) $display("[TB] FAIL cr_line1: got %h expected 0c0", bus); else passes++;
      checks++; if (busy !== 1'b0) $display("[TB] FAIL cr_idle: got %b expected 0", busy); else passes++;
      activity = 0;
      repeat (15) begin
         if (lcd_e || busy) activity++;
         @(negedge clk);
      end
      checks++; if (activity !== 0) $display("[TB] FAIL drop_while_busy: got %0d active cycles expected 0", activity); else passes++;
      send_byte(8'h0D);
      wait_pulse(found, bus, high, waitc);
      checks++; if (!found || bus !== 10'h080) $display("[TB] FAIL cr_line0: got %h expected 080", bus); else passes++;
   endtask

   task automatic test_line_wrap();
      logic       found;
      logic [9:0] bus;
      logic [7:0] d;
      int         high, waitc;
      for (int i = 0; i < 16; i++) begin
         d = 8'h30 + 8'(i);
         send_byte(d);
         wait_pulse(found, bus, high, waitc);
         checks++; if (!found || bus !== {2'b10, d}) $display("[TB] FAIL wrap_char%0d: got %h expected %h", i, bus, {2'b10, d}); else passes++;
      end
      checks++; if (busy !== 1'b1) $display("[TB] FAIL wrap_still_busy: got %b expected 1", busy); else passes++;
      wait_pulse(found, bus, high, waitc);
      checks++; if (!found || bus !== 10'h0C0) $display("[TB] FAIL wrap_line1_cmd: got %h expected 0c0", bus); else passes++;
      checks++; if (busy !== 1'b0) $display("[TB] FAIL wrap_idle: got %b expected 0", busy); else passes++;
      send_byte(8'h58);
      wait_pulse(found, bus, high, waitc);
      checks++; if (!found || bus !== 10'h258) $display("[TB] FAIL wrap_next_char: got %h expected 258", bus); else passes++;
   endtask

   task automatic test_screen_wrap();
      logic       found;
      logic [9:0] bus;
      logic [7:0] d;
      int         high, waitc;
      send_byte(8'h0D);
      wait_pulse(found, bus, high, waitc);
      checks++; if (!found || bus !== 10'h080) $display("[TB] FAIL screen_cr_home: got %h expected 080", bus); else passes++;
      for (int i = 0; i < 32; i++) begin
         d = 8'h40 + 8'(i);
         send_byte(d);
         wait_pulse(found, bus, high, waitc);
         checks++; if (!found || bus !== {2'b10, d}) $display("[TB] FAIL screen_char%0d: got %h expected %h", i, bus, {2'b10, d}); else passes++;
         if (i == 15) begin
            wait_pulse(found, bus, high, waitc);
            checks++; if (!found || bus !== 10'h0C0) $display("[TB] FAIL screen_line1: got %h expected 0c0", bus); else passes++;
         end
      end
      wait_pulse(found, bus, high, waitc);
      checks++; if (!found || bus !== 10'h001) $display("[TB] FAIL screen_clear: got %h expected 001", bus); else passes++;
      checks++; if (waitc !== CLR_C) $display("[TB] FAIL screen_clear_wait: got %0d expected %0d", waitc, CLR_C); else passes++;
      wait_pulse(found, bus, high, waitc);
      checks++; if (!found || bus !== 10'h080) $display("[TB] FAIL screen_home: got %h expected 080", bus); else passes++;
      checks++; if (busy !== 1'b0) $display("[TB] FAIL screen_idle: got %b expected 0", busy); else passes++;
      send_byte(8'h0D);
      wait_pulse(found, bus, high, waitc);
      checks++; if (!found || bus !== 10'h0C0) $display("[TB] FAIL screen_cursor_home: got %h expected 0c0", bus); else passes++;
   endtask

   task automatic test_reset_mid_pulse();
      logic       found;
      logic [9:0] bus;
      int         high, waitc;
      send_byte(8'h41);
      checks++; if (lcd_bus !== 10'h241) $display("[TB] FAIL midrst_setup: got %h expected 241", lcd_bus); else passes++;
      @(negedge clk);
      checks++; if (lcd_e !== 1'b1) $display("[TB] FAIL midrst_in_pulse: got %b expected 1", lcd_e); else passes++;
      reset = 1'b0;
      @(negedge clk);
      checks++; if (lcd_e !== 1'b0) $display("[TB] FAIL midrst_e: got %b expected 0", lcd_e); else passes++;
      checks++; if (busy !== 1'b1) $display("[TB] FAIL midrst_busy: got %b expected 1", busy); else passes++;
      checks++; if (lcd_bus !== 10'h000) $display("[TB] FAIL midrst_bus: got %h expected 000", lcd_bus); else passes++;
      @(negedge clk);
      test_init();
      send_byte(8'h0D);
      wait_pulse(found, bus, high, waitc);
      checks++; if (!found || bus !== 10'h0C0) $display("[TB] FAIL midrst_cursor: got %h expected 0c0", bus); else passes++;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] simulation timed out");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_init();
      test_single_char();
      test_cr_and_discard();
      test_line_wrap();
      test_screen_wrap();
      test_reset_mid_pulse();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/lcd_char_writer.md
LCD_CHAR_WRITER -- requirements
Module: lcd_char_writer

Interface
REQ-001 SHALL have parameter PWRUP_CYC, default 750000, meaning the power-up wait in clocks (15 ms at 50 MHz).
REQ-002 SHALL have parameter E_HIGH_CYC, default 25, meaning the lcd_e high width in clocks.
REQ-003 SHALL have parameter CMD_WAIT_CYC, default 2000, meaning the post-write wait for a normal command or character in clocks.
REQ-004 SHALL have parameter CLR_WAIT_CYC, default 82000, meaning the post-write wait after clear (0x01) in clocks.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port lcd_data, input, 8 bits: the byte from the receive FIFO.
REQ-008 SHALL have port lcd_en, input, 1 bit: byte-valid strobe, one or more cycles.
REQ-009 SHALL have port busy, output, 1 bit: high while the block cannot accept a byte.
REQ-010 SHALL have port lcd_bus, output, 10 bits: {RS, RW, D7..D0} to the panel.
REQ-011 SHALL have port lcd_e, output, 1 bit: panel enable strobe.

Function
REQ-012 SHALL accept a byte only on an edge where lcd_en=1 and busy=0; lcd_en while busy=1 is dropped, with no queueing.
REQ-013 SHALL implement states PWR, SETUP, PULSE, WAIT and IDLE; busy=0 only in IDLE.
REQ-014 After reset release, SHALL stay in PWR for PWRUP_CYC clocks, then issue in order: 0x38, 0x0C, 0x01, 0x06 (RS=0, RW=0).
REQ-015 SHALL run one panel write as follows: SETUP drives lcd_bus for 1 clock with lcd_e=0; PULSE holds lcd_e=1 for E_HIGH_CYC clocks; WAIT holds lcd_e=0 for CMD_WAIT_CYC clocks (CLR_WAIT_CYC if the byte was 0x01).
REQ-016 SHALL keep lcd_bus stable from SETUP through the end of WAIT.
REQ-017 SHALL enter IDLE after the last init command's WAIT, with cursor at line 0, column 0.
REQ-018 On accept at edge N: busy=1 from N+1; SETUP during cycle N+1; lcd_e rises at N+2.
REQ-019 SHALL write printable bytes 0x20-0x7E as data (RS=1, RW=0, D=byte) and then advance the column.
REQ-020 After a write to column 15 of line 0, SHALL automatically issue 0xC0 and set line 1, column 0, before leaving busy.
REQ-021 After a write to column 15 of line 1, SHALL automatically issue 0x01 (long wait) then 0x80, set line 0, column 0, then go to IDLE.
REQ-022 On 0x0D, SHALL move the cursor to column 0 of the other line (0xC0 from line 0; 0x80 from line 1), with no clear.
REQ-023 SHALL discard all other bytes (0x00-0x1F except 0x0D, and 0x7F-0xFF) with no panel write; busy stays 0 for them.
REQ-024 SHALL use counters wide enough for max(PWRUP_CYC, CLR_WAIT_CYC); a delay value of 0 SHALL be treated as 1.
REQ-025 SHALL keep RW=0 always; the panel is never read.

Reset
REQ-026 With reset=0 at an edge: lcd_e=0, lcd_bus=10'h000, busy=1, state=PWR, cursor at 0/0, init step=0, all counters cleared.
REQ-027 On reset mid-operation (during PULSE, WAIT or wrap), lcd_e SHALL be 0 on the next edge; the pending byte and wrap are lost; the full init sequence reruns.

Structure
REQ-028 Shared package lcd_pkg SHALL hold the command constants (FUNC_SET=0x38, DISP_ON=0x0C, CLEAR=0x01, ENTRY=0x06, LINE0=0x80, LINE1=0xC0, CR=0x0D) and the state encoding.
REQ-029 SHALL instantiate one sub-module, lcd_delay_counter: a loadable down-counter with a done flag, used by PWR, PULSE and WAIT.

Verification (PWRUP_CYC=20, E_HIGH_CYC=3, CMD_WAIT_CYC=8, CLR_WAIT_CYC=30)
REQ-030 Reset release -> busy=1; 4 lcd_e pulses with lcd_bus 0x038, 0x00C, 0x001, 0x006; 30-clock gap after 0x001; then busy=0.
REQ-031 lcd_data=0x41 with lcd_en for 1 clock in IDLE -> busy=1 next clock; lcd_bus=0x241; lcd_e high for exactly 3 clocks; busy=0 after 8 wait clocks.
REQ-032 16 bytes 0x30..0x3F, then 0x58 -> after the 16th write, lcd_bus=0x0C0 pulse; then 0x258 is written on line 1.
REQ-033 32 printable bytes -> after the 32nd, pulse 0x001 (30-clock wait) then 0x080; cursor at 0/0.
REQ-034 Send 0x0A, then 0x0D on line 0, then a second lcd_en during busy -> 0x0A: no lcd_e, busy stays 0; 0x0D: 0x0C0 pulse; second byte: no pulse.
REQ-035 Reset=0 during PULSE of 0x241 -> lcd_e=0 and busy=1 next clock; the init sequence from REQ-030 repeats.
